// File: rtl/text_console_pkg.sv
// Shared types and constants for the text console: FSM states, control bytes,
// default screen geometry and the VRAM cell address packing.
package text_console_pkg;

  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 30;
  localparam int COL_W     = 7;
  localparam int ROW_W     = 5;
  localparam int ADDR_W    = ROW_W + COL_W;

  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_FF = 8'h0C;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    SCROLL_RD,
    SCROLL_WR,
    SCROLL_CLR,
    CLR_ALL
  } console_state_t;

  // Row stride is fixed at 128 cells regardless of the visible column count.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/text_console_if.sv
// Byte stream and VRAM port bundle of the text console; master is the console,
// slave is the surrounding system (producer plus VRAM).
interface text_console_if;
  import text_console_pkg::*;

  logic [7:0]        char_i;
  logic              char_valid_i;
  logic              char_ready_o;
  logic [ADDR_W-1:0] vram_addr_o;
  logic              vram_we_o;
  logic [7:0]        vram_wdata_o;
  logic [7:0]        vram_rdata_i;
  logic [COL_W-1:0]  cursor_x_o;
  logic [ROW_W-1:0]  cursor_y_o;
  logic              busy_o;

  modport master (
    input  char_i, char_valid_i, vram_rdata_i,
    output char_ready_o, vram_addr_o, vram_we_o, vram_wdata_o,
    output cursor_x_o, cursor_y_o, busy_o
  );

  modport slave (
    output char_i, char_valid_i, vram_rdata_i,
    input  char_ready_o, vram_addr_o, vram_we_o, vram_wdata_o,
    input  cursor_x_o, cursor_y_o, busy_o
  );

endinterface

// File: rtl/text_console_cell_sweeper.sv
// Row-major cell counter used by the scroll and clear sweeps; start loads a
// first row at column 0, done flags the last visible cell.
module text_console_cell_sweeper
  import text_console_pkg::*;
#(
  parameter int COLS = TEXT_COLS,
  parameter int ROWS = TEXT_ROWS
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start,
  input  logic [ROW_W-1:0] first_row,
  input  logic             step,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             done
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  // Reset parks the counter at the origin so the power-up clear starts there.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      row <= '0;
      col <= '0;
    end else if (start) begin
      row <= first_row;
      col <= '0;
    end else if (step) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  assign done = (row == LAST_ROW) && (col == LAST_COL);

endmodule

// File: rtl/text_console.sv
// Character stream front end for the text-mode VRAM: cursor handling, control
// codes, one-line scroll by row copy and full-screen clear.
module text_console
  import text_console_pkg::*;
#(
  parameter int         COLS      = TEXT_COLS,
  parameter int         ROWS      = TEXT_ROWS,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic clk_i,
  input  logic reset_i,
  text_console_if.master bus
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  console_state_t   state_q;
  logic [COL_W-1:0] x_q;
  logic [ROW_W-1:0] y_q;
  logic [7:0]       data_q;
  logic             bs_q;

  logic             accept;
  logic             sw_start;
  logic [ROW_W-1:0] sw_first_row;
  logic             sw_step;
  logic [ROW_W-1:0] sw_row;
  logic [COL_W-1:0] sw_col;
  logic             sw_done;

  assign accept = bus.char_valid_i && (state_q == IDLE);

  text_console_cell_sweeper #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cell_sweeper (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start     (sw_start),
    .first_row (sw_first_row),
    .step      (sw_step),
    .row       (sw_row),
    .col       (sw_col),
    .done      (sw_done)
  );

  // The sweeper is loaded on the cycle that enters a sweep so its first cell is ready.
  always_comb begin
    sw_start     = 1'b0;
    sw_first_row = '0;
    sw_step      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && (bus.char_i == ASCII_LF) && (y_q == LAST_ROW)) begin
          sw_start     = 1'b1;
          sw_first_row = ROW_W'(1);
        end else if (accept && (bus.char_i == ASCII_FF)) begin
          sw_start = 1'b1;
        end
      end
      WRITE: begin
        if (!bs_q && (x_q == LAST_COL) && (y_q == LAST_ROW)) begin
          sw_start     = 1'b1;
          sw_first_row = ROW_W'(1);
        end
      end
      SCROLL_WR: begin
        if (sw_done) begin
          sw_start     = 1'b1;
          sw_first_row = LAST_ROW;
        end else begin
          sw_step = 1'b1;
        end
      end
      SCROLL_CLR, CLR_ALL: sw_step = !sw_done;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= CLR_ALL;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= FILL_CHAR;
      bs_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (bus.char_i)
              ASCII_CR: x_q <= '0;
              ASCII_LF: begin
                x_q <= '0;
                if (y_q < LAST_ROW) y_q <= y_q + ROW_W'(1);
                else                state_q <= SCROLL_RD;
              end
              ASCII_BS: begin
                if (x_q != '0) begin
                  x_q     <= x_q - COL_W'(1);
                  data_q  <= FILL_CHAR;
                  bs_q    <= 1'b1;
                  state_q <= WRITE;
                end
              end
              ASCII_FF: state_q <= CLR_ALL;
              default: begin
                data_q  <= bus.char_i;
                bs_q    <= 1'b0;
                state_q <= WRITE;
              end
            endcase
          end
        end
        WRITE: begin
          state_q <= IDLE;
          if (!bs_q) begin
            if (x_q < LAST_COL) begin
              x_q <= x_q + COL_W'(1);
            end else begin
              x_q <= '0;
              if (y_q < LAST_ROW) y_q <= y_q + ROW_W'(1);
              else                state_q <= SCROLL_RD;
            end
          end
        end
        SCROLL_RD: state_q <= SCROLL_WR;
        SCROLL_WR: state_q <= sw_done ? SCROLL_CLR : SCROLL_RD;
        SCROLL_CLR: begin
          if (sw_done) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= LAST_ROW;
          end
        end
        CLR_ALL: begin
          if (sw_done) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
          end
        end
        default: state_q <= CLR_ALL;
      endcase
    end
  end

  // Reset gates the write strobe directly so an aborted sweep stops writing at once.
  always_comb begin
    bus.vram_addr_o  = cell_addr(y_q, x_q);
    bus.vram_we_o    = 1'b0;
    bus.vram_wdata_o = FILL_CHAR;
    case (state_q)
      WRITE: begin
        bus.vram_we_o    = 1'b1;
        bus.vram_wdata_o = data_q;
      end
      SCROLL_RD: bus.vram_addr_o = cell_addr(sw_row, sw_col);
      SCROLL_WR: begin
        bus.vram_addr_o  = cell_addr(sw_row - ROW_W'(1), sw_col);
        bus.vram_we_o    = 1'b1;
        bus.vram_wdata_o = bus.vram_rdata_i;
      end
      SCROLL_CLR, CLR_ALL: begin
        bus.vram_addr_o = cell_addr(sw_row, sw_col);
        bus.vram_we_o   = 1'b1;
      end
      default: ;
    endcase
    if (reset_i) bus.vram_we_o = 1'b0;
  end

  assign bus.char_ready_o = (state_q == IDLE);
  assign bus.busy_o       = (state_q == SCROLL_RD) || (state_q == SCROLL_WR) ||
                            (state_q == SCROLL_CLR) || (state_q == CLR_ALL);
  assign bus.cursor_x_o   = x_q;
  assign bus.cursor_y_o   = y_q;

endmodule
